pll_lock_supervisor: RTL



---
 rtl/pll_sup_pkg.sv | 18 +
 rtl/sync_filter.sv | 58 +++++
 rtl/pll_lock_supervisor.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned LOSS_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2
    } state_e;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_filter.sv
// Input synchronizer followed by a consecutive-level counter that emits one
// pulse when the watched level has persisted for COUNT synced cycles.
module sync_filter
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COUNT       = 16,
    parameter bit          ACTIVE_LOW  = 1'b0
)
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic synced,
    output logic qualified_c
);
    import pll_sup_pkg::*;

    localparam int unsigned CNT_W = cnt_width(COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   armed_q;
    logic                   level;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Polarity is applied after synchronization so a cleared chain reads as "lock low".
    assign level       = synced ^ ACTIVE_LOW;
    assign qualified_c = level && armed_q && (cnt_q == CNT_MAX);

    // Saturating run counter; a held level fires once until it drops for a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end else if (!level) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (qualified_c) begin
                armed_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Holds the core in reset until PLL lock is stable, re-asserts it on filtered
// lock loss or a debounced button press, and counts lock-loss events.
module pll_lock_supervisor
#(
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter int unsigned LOSS_FILTER   = 16,
    parameter int unsigned DEBOUNCE      = 500000,
    parameter int unsigned SYNC_STAGES   = 2
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_lock,
    input  logic       i_btn,
    output logic       o_core_rst,
    output logic       o_ready,
    output logic [7:0] o_loss_cnt,
    output logic [1:0] o_state
);
    import pll_sup_pkg::*;

    localparam int unsigned STAB_W = cnt_width(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

    state_e              state_q, state_nxt;
    logic [STAB_W-1:0]   stab_q, stab_nxt;
    logic [LOSS_W-1:0]   loss_cnt_q, loss_cnt_nxt;
    logic                core_rst_q;
    logic                ready_q;

    logic                lock_synced;
    logic                loss_c;
    logic                btn_synced_unused;
    logic                press_c;

    sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .COUNT       (LOSS_FILTER),
        .ACTIVE_LOW  (1'b1)
    ) u_lock_filter (
        .clk         (clk),
        .rst         (rst),
        .din         (i_lock),
        .synced      (lock_synced),
        .qualified_c (loss_c)
    );

    sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .COUNT       (DEBOUNCE),
        .ACTIVE_LOW  (1'b0)
    ) u_btn_filter (
        .clk         (clk),
        .rst         (rst),
        .din         (i_btn),
        .synced      (btn_synced_unused),
        .qualified_c (press_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_LOCK;
            stab_q     <= '0;
            loss_cnt_q <= '0;
            core_rst_q <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            stab_q     <= stab_nxt;
            loss_cnt_q <= loss_cnt_nxt;
            core_rst_q <= (state_nxt != RUN);
            ready_q    <= (state_nxt == RUN);
        end
    end

    // Next state: normal progression, then button, then lock loss (highest priority).
    always_comb begin
        state_nxt    = WAIT_LOCK;
        stab_nxt     = '0;
        loss_cnt_nxt = loss_cnt_q;

        case (state_q)
            WAIT_LOCK: begin
                if (lock_synced) begin
                    state_nxt = STABILIZE;
                end
            end
            STABILIZE: begin
                if (!lock_synced) begin
                    state_nxt = WAIT_LOCK;
                end else if (stab_q == STAB_MAX) begin
                    state_nxt = RUN;
                end else begin
                    state_nxt = STABILIZE;
                    stab_nxt  = stab_q + STAB_W'(1);
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase

        if (press_c) begin
            state_nxt = lock_synced ? STABILIZE : WAIT_LOCK;
            stab_nxt  = '0;
        end

        if ((state_q == RUN) && loss_c) begin
            state_nxt = WAIT_LOCK;
            stab_nxt  = '0;
            if (loss_cnt_q != '1) begin
                loss_cnt_nxt = loss_cnt_q + LOSS_W'(1);
            end
        end
    end

    assign o_core_rst = core_rst_q;
    assign o_ready    = ready_q;
    assign o_loss_cnt = loss_cnt_q;
    assign o_state    = state_q;

endmodule
